qam16_mapper: RTL and testbench

Transmit-side 16-QAM symbol mapper that sits directly upstream of the pilot inserter. It collects a serial bit stream into 4-bit groups, Gray-maps each group to signed I/Q levels in the 16-bit fixed-point format used by the transmit chain, and counts symbols into 400-symbol frames. It also raises the level-type `start` enable that the pilot inserter expects.

---
 rtl/qam16_mapper_if.sv | 21 ++
 rtl/qam16_mapper.sv | 50 +++++
 tb/tb_qam16_mapper.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/qam16_mapper_if.sv
// qam16_mapper_if: serial bit input and mapped I/Q symbol output of the 16-QAM mapper
interface qam16_mapper_if #(
    parameter int width_data = 16
);
    logic                  bit_in;
    logic                  bit_valid;
    logic [width_data-1:0] i_out;
    logic [width_data-1:0] q_out;
    logic                  sym_valid;
    logic                  sym_last;
    logic [8:0]            sym_idx;
    logic                  start;
    modport master (
        input  bit_in, bit_valid,
        output i_out, q_out, sym_valid, sym_last, sym_idx, start
    );
    modport slave (
        output bit_in, bit_valid,
        input  i_out, q_out, sym_valid, sym_last, sym_idx, start
    );
endinterface

// File: rtl/qam16_mapper.sv
// qam16_mapper: gathers 4-bit groups, Gray-maps them to 16-QAM I/Q levels and counts symbols into frames
module qam16_mapper #(
    parameter int width_data = 16,
    parameter int frame_len  = 400
) (
    input logic            clk,
    input logic            rst,
    qam16_mapper_if.master bus
);
    logic [1:0] bit_cnt;
    logic [2:0] shift;
    logic [8:0] sym_cnt;
    logic       last;
    // Level in units of 1.0 as a 3-bit signed integer, then widened to s.3.12
    function automatic logic [width_data-1:0] level(input logic [1:0] p);
        logic [2:0] lv;
        lv = p == 2'b00 ? 3'b101 : p == 2'b01 ? 3'b111 : p == 2'b11 ? 3'b001 : 3'b011;
        return {{(width_data-15){lv[2]}}, lv, 12'b0};
    endfunction
    always_comb last = sym_cnt == 9'(frame_len - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= '0;
            shift         <= '0;
            sym_cnt       <= '0;
            bus.i_out     <= '0;
            bus.q_out     <= '0;
            bus.sym_valid <= 1'b0;
            bus.sym_last  <= 1'b0;
            bus.sym_idx   <= '0;
            bus.start     <= 1'b0;
        end else begin
            bus.sym_valid <= 1'b0;
            bus.sym_last  <= 1'b0;
            if (bus.bit_valid) begin
                bit_cnt <= bit_cnt + 2'd1;
                shift   <= {shift[1:0], bus.bit_in};
                if (bit_cnt == 2'd3) begin
                    bus.i_out     <= level(shift[2:1]);
                    bus.q_out     <= level({shift[0], bus.bit_in});
                    bus.sym_valid <= 1'b1;
                    bus.sym_last  <= last;
                    bus.sym_idx   <= sym_cnt;
                    bus.start     <= 1'b1;
                    sym_cnt       <= last ? 9'd0 : sym_cnt + 9'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_qam16_mapper.sv
// tb_qam16_mapper: directed self-checking bench for qam16_mapper
module tb_qam16_mapper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] lvl [4] = '{16'hD000, 16'hF000, 16'h3000, 16'h1000};
    qam16_mapper_if #(.width_data(16)) bus();
    qam16_mapper #(.width_data(16), .frame_len(400)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        @(negedge clk);
        bus.bit_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask
    task automatic send_nib(input logic [3:0] n);
        for (int k = 3; k >= 0; k--) send_bit(n[k]);
    endtask
    task automatic test_reset();
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        rst           = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({bus.i_out, bus.q_out, bus.sym_valid, bus.sym_last, bus.sym_idx, bus.start} !== 45'd0) begin
                fails++;
                $display("FAIL reset cycle %0d: i=%h q=%h v=%b l=%b idx=%0d st=%b, required all zero",
                         c, bus.i_out, bus.q_out, bus.sym_valid, bus.sym_last, bus.sym_idx, bus.start);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.bit_valid = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            send_bit(k == 3 ? 1'b0 : k == 2 ? 1'b0 : 1'b1);
            tests++;
            if (bus.sym_valid !== 1'b0 || bus.start !== 1'b0) begin
                fails++;
                $display("FAIL reset_first_group bit %0d: v=%b st=%b, required 0 0", k, bus.sym_valid, bus.start);
            end
        end
        send_bit(1'b1);
        tests++;
        if (bus.sym_valid !== 1'b1 || bus.start !== 1'b1 || bus.i_out !== 16'hD000 || bus.q_out !== 16'h1000 || bus.sym_idx !== 9'd0) begin
            fails++;
            $display("FAIL reset_first_symbol: v=%b st=%b i=%h q=%h idx=%0d, required 1 1 D000 1000 0",
                     bus.sym_valid, bus.start, bus.i_out, bus.q_out, bus.sym_idx);
        end
    endtask
    task automatic test_mapping();
        logic [3:0] n;
        for (int s = 0; s < 16; s++) begin
            n = 4'(s);
            for (int k = 3; k >= 0; k--) begin
                send_bit(n[k]);
                if (k != 0) begin
                    tests++;
                    if (bus.sym_valid !== 1'b0) begin
                        fails++;
                        $display("FAIL map_gap nib %h bit %0d: v=%b, required 0", n, k, bus.sym_valid);
                    end
                end
            end
            tests++;
            if (bus.sym_valid !== 1'b1 || bus.i_out !== lvl[n[3:2]] || bus.q_out !== lvl[n[1:0]] ||
                bus.sym_idx !== 9'(s + 1) || bus.sym_last !== 1'b0 || bus.start !== 1'b1) begin
                fails++;
                $display("FAIL map nib %h: v=%b i=%h q=%h idx=%0d l=%b st=%b, required 1 %h %h %0d 0 1",
                         n, bus.sym_valid, bus.i_out, bus.q_out, bus.sym_idx, bus.sym_last, bus.start,
                         lvl[n[3:2]], lvl[n[1:0]], s + 1);
            end
        end
        send_nib(4'h6);
        tests++;
        if (bus.i_out !== 16'hF000 || bus.q_out !== 16'h3000) begin
            fails++;
            $display("FAIL map_spot 6: i=%h q=%h, required F000 3000", bus.i_out, bus.q_out);
        end
    endtask
    task automatic test_gapped();
        int pulses = 0;
        logic [3:0] n = 4'h9;
        for (int k = 3; k >= 0; k--) begin
            send_bit(n[k]);
            pulses += int'(bus.sym_valid);
            for (int g = 0; g < 2; g++) begin
                idle();
                pulses += int'(bus.sym_valid);
                tests++;
                if (k != 0 && (bus.i_out !== 16'hF000 || bus.q_out !== 16'h3000)) begin
                    fails++;
                    $display("FAIL gap_hold bit %0d: i=%h q=%h, required F000 3000", k, bus.i_out, bus.q_out);
                end else if (k == 0 && (bus.i_out !== 16'h3000 || bus.q_out !== 16'hF000 || bus.start !== 1'b1)) begin
                    fails++;
                    $display("FAIL gap_result: i=%h q=%h st=%b, required 3000 F000 1", bus.i_out, bus.q_out, bus.start);
                end
            end
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL gap_pulses: %0d pulses, required 1", pulses);
        end
    endtask
    task automatic test_mid_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        bus.bit_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (bus.start !== 1'b0 || bus.sym_idx !== 9'd0 || bus.i_out !== 16'h0) begin
            fails++;
            $display("FAIL midrst_clear: st=%b idx=%0d i=%h, required 0 0 0000", bus.start, bus.sym_idx, bus.i_out);
        end
        @(negedge clk);
        rst = 1'b0;
        send_nib(4'hC);
        tests++;
        if (bus.sym_valid !== 1'b1 || bus.i_out !== 16'h1000 || bus.q_out !== 16'hD000 ||
            bus.sym_idx !== 9'd0 || bus.start !== 1'b1) begin
            fails++;
            $display("FAIL midrst_symbol: v=%b i=%h q=%h idx=%0d st=%b, required 1 1000 D000 0 1",
                     bus.sym_valid, bus.i_out, bus.q_out, bus.sym_idx, bus.start);
        end
    endtask
    task automatic test_frame_wrap();
        int lasts = 0;
        @(negedge clk);
        bus.bit_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 401; s++) begin
            send_nib(4'(s));
            lasts += int'(bus.sym_last);
            if (s == 0 || s >= 398) begin
                tests++;
                if (bus.sym_valid !== 1'b1 || bus.sym_idx !== 9'(s % 400) || bus.sym_last !== (s == 399)) begin
                    fails++;
                    $display("FAIL wrap sym %0d: v=%b idx=%0d l=%b, required 1 %0d %b",
                             s, bus.sym_valid, bus.sym_idx, bus.sym_last, s % 400, s == 399);
                end
            end
        end
        idle();
        tests++;
        if (lasts != 1 || bus.sym_last !== 1'b0 || bus.sym_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_last_count: lasts=%0d l=%b v=%b, required 1 0 0", lasts, bus.sym_last, bus.sym_valid);
        end
    endtask
    initial begin
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        test_reset();
        test_mapping();
        test_gapped();
        test_mid_reset();
        test_frame_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
